// File: rtl/ball_physics_engine_if.sv
// Paddle-hit input and ball-state output bundle of the pong ball engine.
// The game controller drives the hit fields; the engine drives the ball fields.
interface ball_physics_engine_if;
    logic       hit_valid;
    logic [9:0] est_speed;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       moving_left;
    logic       step_strobe;
    logic       miss_pulse;

    modport master (
        output hit_valid, est_speed,
        input  ball_x, ball_y, moving_left, step_strobe, miss_pulse
    );

    modport slave (
        input  hit_valid, est_speed,
        output ball_x, ball_y, moving_left, step_strobe, miss_pulse
    );
endinterface

// File: rtl/ball_physics_engine.sv
// Pong ball motion: stepped x/y movement, gravity, wall bounces, paddle-speed scaling, miss and re-serve.
// Optional: define BALL_SPIN_EN to let a paddle hit add est_speed>>3 to the y velocity.
module ball_physics_engine #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 20,
    parameter int X_STEP      = 4,
    parameter int BASE_PERIOD = 270000,
    parameter int MIN_PERIOD  = 2000,
    parameter int GRAV_DIV    = 4,
    parameter int VMAX        = 7,
    parameter int SERVE_X     = 100,
    parameter int SERVE_Y     = 80,
    parameter int SERVE_VY    = -3,
    parameter int MISS_STEPS  = 32,
    parameter int CNT_W       = 8
) (
    input  logic                   clk_25MHZ,
    input  logic                   reset_n,
    input  logic                   game_en,
    input  logic                   upscale,
    ball_physics_engine_if.slave   bus,
    output logic [CNT_W-1:0]       hit_count,
    output logic [CNT_W-1:0]       miss_count
);
    localparam int PW = $clog2(BASE_PERIOD + 1);
    localparam int GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam int MW = (MISS_STEPS > 1) ? $clog2(MISS_STEPS) : 1;
    localparam logic [9:0]        RIGHT_WALL = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0]        X_STEP_V   = 10'(X_STEP);
    localparam logic signed [11:0] VMAX_P    = 12'(VMAX);
    localparam logic signed [11:0] VMAX_N    = 12'(-VMAX);
    localparam logic [31:0]       BASE_32    = 32'(BASE_PERIOD);
    localparam logic [31:0]       MIN_32     = 32'(MIN_PERIOD);

    typedef enum logic [2:0] {IDLE, SERVE, RUN_LEFT, RUN_RIGHT, MISS} state_t;

    state_t             state;
    logic [9:0]         x_q, y_q;
    logic signed [11:0] vy_q;
    logic [PW-1:0]      period_q, tick_q;
    logic [GW-1:0]      grav_q;
    logic [MW-1:0]      miss_q;
    logic               step_q, miss_pulse_q, ml_q;
    logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

    function automatic logic signed [11:0] clamp_v(input logic signed [11:0] v);
        if (v > VMAX_P)      return VMAX_P;
        else if (v < VMAX_N) return VMAX_N;
        else                 return v;
    endfunction

    logic               tick_end, grav_wrap;
    logic [GW-1:0]      grav_next;
    logic signed [11:0] y_max, y_new, vy_grav, vy_step, vy_hit;
    logic [9:0]         y_step, speed_s;
    logic [10:0]        x_sum;
    logic [31:0]        quot;
    logic [PW-1:0]      hit_period;

    assign tick_end  = (tick_q == period_q - PW'(1));
    assign grav_wrap = (grav_q == GW'(GRAV_DIV - 1));
    assign grav_next = grav_wrap ? '0 : grav_q + GW'(1);
    assign y_max     = upscale ? 12'(SCREEN_H - 1) : 12'(SCREEN_H / 2 - 1);
    assign y_new     = $signed({2'b00, y_q}) + vy_q;
    assign x_sum     = {1'b0, x_q} + 11'(X_STEP);
    assign speed_s   = (bus.est_speed == '0) ? 10'd1 : bus.est_speed;

    // Bounce reflects the post-gravity velocity, while position uses the pre-gravity one.
    always_comb begin
        vy_grav = grav_wrap ? clamp_v(vy_q + 12'sd1) : vy_q;
        y_step  = y_new[9:0];
        vy_step = vy_grav;
        if (y_new >= y_max) begin
            y_step  = y_max[9:0];
            vy_step = -vy_grav;
        end else if (y_new <= 12'sd0) begin
            y_step  = '0;
            vy_step = -vy_grav;
        end
    end

    always_comb begin
        quot = BASE_32 / {22'b0, speed_s};
        if (quot < MIN_32) quot = MIN_32;
        hit_period = PW'(quot);
    end

`ifdef BALL_SPIN_EN
    assign vy_hit = clamp_v(vy_q + $signed({5'b00000, bus.est_speed[9:3]}));
`else
    assign vy_hit = vy_q;
`endif

    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            x_q          <= 10'(SERVE_X);
            y_q          <= 10'(SERVE_Y);
            vy_q         <= 12'(SERVE_VY);
            period_q     <= PW'(BASE_PERIOD);
            tick_q       <= '0;
            grav_q       <= '0;
            miss_q       <= '0;
            step_q       <= 1'b0;
            miss_pulse_q <= 1'b0;
            ml_q         <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            step_q       <= 1'b0;
            miss_pulse_q <= 1'b0;
            if (!game_en) begin
                state <= IDLE;
                ml_q  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: state <= SERVE;
                    SERVE: begin
                        x_q      <= 10'(SERVE_X);
                        y_q      <= 10'(SERVE_Y);
                        vy_q     <= 12'(SERVE_VY);
                        period_q <= PW'(BASE_PERIOD);
                        tick_q   <= '0;
                        grav_q   <= '0;
                        miss_q   <= '0;
                        state    <= RUN_LEFT;
                        ml_q     <= 1'b1;
                    end
                    RUN_LEFT: begin
                        // A hit on the step cycle wins; that step is dropped.
                        if (bus.hit_valid) begin
                            state    <= RUN_RIGHT;
                            ml_q     <= 1'b0;
                            period_q <= hit_period;
                            tick_q   <= '0;
                            vy_q     <= vy_hit;
                            if (!(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                        end else if (tick_end) begin
                            tick_q <= '0;
                            step_q <= 1'b1;
                            grav_q <= grav_next;
                            y_q    <= y_step;
                            vy_q   <= vy_step;
                            if (x_q < X_STEP_V) begin
                                x_q          <= '0;
                                state        <= MISS;
                                ml_q         <= 1'b0;
                                miss_pulse_q <= 1'b1;
                                if (!(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                            end else begin
                                x_q <= x_q - X_STEP_V;
                            end
                        end else begin
                            tick_q <= tick_q + PW'(1);
                        end
                    end
                    RUN_RIGHT: begin
                        if (tick_end) begin
                            tick_q <= '0;
                            step_q <= 1'b1;
                            grav_q <= grav_next;
                            y_q    <= y_step;
                            vy_q   <= vy_step;
                            if (x_sum >= {1'b0, RIGHT_WALL}) begin
                                x_q   <= RIGHT_WALL;
                                state <= RUN_LEFT;
                                ml_q  <= 1'b1;
                            end else begin
                                x_q <= x_sum[9:0];
                            end
                        end else begin
                            tick_q <= tick_q + PW'(1);
                        end
                    end
                    MISS: begin
                        if (tick_end) begin
                            tick_q <= '0;
                            if (miss_q == MW'(MISS_STEPS - 1)) state <= SERVE;
                            else miss_q <= miss_q + MW'(1);
                        end else begin
                            tick_q <= tick_q + PW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ball_x      = x_q;
    assign bus.ball_y      = y_q;
    assign bus.moving_left = ml_q;
    assign bus.step_strobe = step_q;
    assign bus.miss_pulse  = miss_pulse_q;
    assign hit_count       = hit_cnt_q;
    assign miss_count      = miss_cnt_q;
endmodule

// File: tb/tb_ball_physics_engine.sv
// Scoreboard bench for ball_physics_engine: each expected motion step is queued by the stimulus
// and checked by a monitor whenever the engine strobes a step.
module tb_ball_physics_engine;
    localparam int CNT_W = 8;

    logic             clk_25MHZ = 1'b0;
    logic             reset_n;
    logic             game_en;
    logic             upscale;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    ball_physics_engine_if bus ();

    ball_physics_engine #(
        .SCREEN_W   (64),
        .BALL_SIZE  (4),
        .BASE_PERIOD(8),
        .MIN_PERIOD (2),
        .MISS_STEPS (2),
        .SERVE_X    (102),
        .SERVE_Y    (238),
        .SERVE_VY   (3),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_25MHZ (clk_25MHZ),
        .reset_n   (reset_n),
        .game_en   (game_en),
        .upscale   (upscale),
        .bus       (bus),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    always #20 clk_25MHZ = ~clk_25MHZ;

    typedef struct {
        int x; int y; int ml; int miss; int hc; int mc; int gap;
    } ev_t;

    ev_t exp_q[$];
    ev_t cur;
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic push(input int x, input int y, input int ml, input int miss,
                        input int hc, input int mc, input int gap);
        ev_t e;
        e.x = x; e.y = y; e.ml = ml; e.miss = miss; e.hc = hc; e.mc = mc; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_steps(input int n);
        int seen;
        int budget;
        seen = 0;
        budget = 0;
        while (seen < n && budget < 400) begin
            @(negedge clk_25MHZ);
            budget++;
            if (bus.step_strobe) seen++;
        end
        chk("step_wait", seen, n);
    endtask

    // Monitor: gap is measured from the latest strobe, accepted hit or entry into RUN_LEFT.
    int               cyc = 0;
    int               ref_cyc = 0;
    int               ev_idx = 0;
    logic             prev_ml = 1'b0;
    logic [CNT_W-1:0] prev_hc = '0;

    always @(negedge clk_25MHZ) begin
        cyc++;
        if (bus.miss_pulse) chk("miss_with_step", bus.step_strobe, 1);
        if (bus.step_strobe) begin
            ev_idx++;
            chk($sformatf("step%0d_expected", ev_idx), int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                chk($sformatf("step%0d_x", ev_idx), bus.ball_x, cur.x);
                chk($sformatf("step%0d_y", ev_idx), bus.ball_y, cur.y);
                chk($sformatf("step%0d_moving_left", ev_idx), bus.moving_left, cur.ml);
                chk($sformatf("step%0d_miss_pulse", ev_idx), bus.miss_pulse, cur.miss);
                chk($sformatf("step%0d_hit_count", ev_idx), hit_count, cur.hc);
                chk($sformatf("step%0d_miss_count", ev_idx), miss_count, cur.mc);
                if (cur.gap != 0) chk($sformatf("step%0d_gap", ev_idx), cyc - ref_cyc, cur.gap);
            end
        end
        if (bus.step_strobe || hit_count != prev_hc || (bus.moving_left && !prev_ml)) ref_cyc = cyc;
        prev_ml = bus.moving_left;
        prev_hc = hit_count;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    int p1_y[26] = '{241, 244, 247, 250, 254, 258, 262, 266, 271, 276, 281, 286, 292,
                     298, 304, 310, 317, 324, 331, 338, 345, 352, 359, 366, 239, 232};
    int p2_x[13] = '{98, 94, 90, 60, 56, 52, 56, 60, 56, 60, 56, 60, 56};
`ifdef BALL_SPIN_EN
    int p2_y[13] = '{239, 236, 233, 230, 228, 226, 224, 222, 221, 228, 235, 239, 232};
`else
    int p2_y[13] = '{239, 236, 233, 230, 228, 226, 224, 222, 221, 220, 219, 218, 218};
`endif
    int p2_ml[13]  = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
    int p2_hc[13]  = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 4, 4};
    int p2_gap[13] = '{8, 8, 8, 2, 2, 2, 8, 8, 8, 2, 2, 2, 2};

    initial begin
        int cnt;
        reset_n = 1'b0;
        game_en = 1'b0;
        upscale = 1'b1;
        bus.hit_valid = 1'b0;
        bus.est_speed = '0;
        repeat (3) @(negedge clk_25MHZ);
        chk("rst_x", bus.ball_x, 102);
        chk("rst_y", bus.ball_y, 238);
        chk("rst_moving_left", bus.moving_left, 0);
        chk("rst_step", bus.step_strobe, 0);
        chk("rst_miss", bus.miss_pulse, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_25MHZ);
        chk("idle_x", bus.ball_x, 102);
        chk("idle_moving_left", bus.moving_left, 0);

        // Serve, fall with gravity, clamp on upscale change, then miss at the left edge.
        for (int k = 1; k <= 26; k++)
            push((k == 26) ? 0 : 102 - 4 * k, p1_y[k-1], (k == 26) ? 0 : 1,
                 (k == 26) ? 1 : 0, 0, (k == 26) ? 1 : 0, 8);
        for (int k = 0; k < 13; k++)
            push(p2_x[k], p2_y[k], p2_ml[k], 0, p2_hc[k], 1, p2_gap[k]);
        game_en = 1'b1;
        @(negedge clk_25MHZ);
        chk("serve_moving_left", bus.moving_left, 0);
        @(negedge clk_25MHZ);
        chk("run_left_moving_left", bus.moving_left, 1);
        wait_steps(24);
        upscale = 1'b0;
        wait_steps(2);
        bus.hit_valid = 1'b1;
        bus.est_speed = 10'd4;
        @(negedge clk_25MHZ);
        bus.hit_valid = 1'b0;
        cnt = 1;
        while (!bus.moving_left && cnt < 60) begin
            @(negedge clk_25MHZ);
            cnt++;
        end
        chk("reserve_latency", cnt, 17);
        chk("reserve_x", bus.ball_x, 102);
        chk("reserve_y", bus.ball_y, 238);
        chk("miss_hit_ignored", hit_count, 0);

        // Hit (est 4) followed by an ignored hit in RUN_RIGHT.
        wait_steps(3);
        bus.hit_valid = 1'b1;
        bus.est_speed = 10'd4;
        @(negedge clk_25MHZ);
        chk("hit1_moving_left", bus.moving_left, 0);
        chk("hit1_count", hit_count, 1);
        bus.est_speed = 10'd1000;
        @(negedge clk_25MHZ);
        bus.hit_valid = 1'b0;
        wait_steps(3);
        bus.hit_valid = 1'b1;
        bus.est_speed = 10'd0;
        @(negedge clk_25MHZ);
        bus.hit_valid = 1'b0;
        wait_steps(3);
        bus.hit_valid = 1'b1;
        bus.est_speed = 10'd1000;
        @(negedge clk_25MHZ);
        bus.hit_valid = 1'b0;
        wait_steps(2);
        // Hit lands on the step cycle.
        @(negedge clk_25MHZ);
        bus.hit_valid = 1'b1;
        bus.est_speed = 10'd4;
        @(negedge clk_25MHZ);
        bus.hit_valid = 1'b0;
        chk("coincident_step_dropped", bus.step_strobe, 0);
        chk("coincident_hit_count", hit_count, 4);
        wait_steps(2);

        // Asynchronous reset mid-flight, then a fresh serve.
        #7 reset_n = 1'b0;
        #1;
        chk("midrst_x", bus.ball_x, 102);
        chk("midrst_y", bus.ball_y, 238);
        chk("midrst_moving_left", bus.moving_left, 0);
        chk("midrst_hit_count", hit_count, 0);
        chk("midrst_miss_count", miss_count, 0);
        chk("midrst_pending", exp_q.size(), 0);
        push(98, 239, 1, 0, 0, 0, 8);
        @(negedge clk_25MHZ);
        reset_n = 1'b1;
        wait_steps(1);

        game_en = 1'b0;
        @(negedge clk_25MHZ);
        chk("stop_moving_left", bus.moving_left, 0);
        chk("stop_x_held", bus.ball_x, 98);
        chk("stop_y_held", bus.ball_y, 239);
        repeat (30) @(negedge clk_25MHZ);
        chk("leftover_events", exp_q.size(), 0);
        chk("idle_x_held", bus.ball_x, 98);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
